// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, splits the instruction word for the decoder,
// applies taken branches, and stops on halt unless the decoder is in prep mode.
module fetch_unit #(
    parameter int                PC_W       = 10,
    parameter int                INSTR_W    = 9,
    parameter logic [PC_W-1:0]   START_ADDR = '0,
    parameter int                CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    instrAddr,
    input  logic [INSTR_W-1:0] instrData,
    input  logic               controlBranch,
    input  logic               aluZero,
    input  logic [7:0]         branchOffset,
    output logic [2:0]         opcode,
    output logic               lastBit,
    output logic [5:0]         operand,
    output logic               running,
    output logic               done,
    output logic [CNT_W-1:0]   cycleCount
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            prep_shadow;
    logic [2:0]      raw_op;
    logic            is_halt;
    logic            take_branch;
    logic [PC_W-1:0] br_off;

    assign raw_op      = instrData[8:6];
    assign is_halt     = (raw_op == 3'b111) && !prep_shadow;
    assign take_branch = controlBranch && aluZero;
    assign br_off      = PC_W'($signed(branchOffset));

    assign instrAddr = pc;
    // Outside RUN the decoder sees a bubble opcode so nothing gets written.
    assign opcode    = running ? raw_op       : 3'b110;
    assign lastBit   = running ? instrData[0] : 1'b0;
    assign operand   = running ? instrData[5:0] : 6'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            prep_shadow <= 1'b0;
            cycleCount  <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= START_ADDR;
                        prep_shadow <= 1'b0;
                        cycleCount  <= '0;
                        running     <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycleCount != '1)
                        cycleCount <= cycleCount + 1'b1;
                    if (is_halt) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (take_branch) begin
                        pc <= pc + br_off;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                    // Track decoder prep mode: PREP arms it, any real op below 101 consumes it.
                    if (!prep_shadow && raw_op == 3'b000)
                        prep_shadow <= 1'b1;
                    else if (prep_shadow && raw_op <= 3'b100)
                        prep_shadow <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

    localparam logic [8:0] INC  = 9'b001_000001;
    localparam logic [8:0] PREP = 9'b000_000000;

    logic       clk = 1'b0;
    logic       reset, start, controlBranch, aluZero;
    logic [7:0] branchOffset;
    logic [9:0] instrAddr;
    logic [8:0] instrData;
    logic [2:0] opcode;
    logic       lastBit, running, done;
    logic [5:0] operand;
    logic [15:0] cycleCount;
    logic [8:0] mem [1024];

    int n_vec = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start),
        .instrAddr(instrAddr), .instrData(instrData),
        .controlBranch(controlBranch), .aluZero(aluZero), .branchOffset(branchOffset),
        .opcode(opcode), .lastBit(lastBit), .operand(operand),
        .running(running), .done(done), .cycleCount(cycleCount)
    );

    assign instrData = mem[instrAddr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill(input logic [8:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; controlBranch = 1'b0; aluZero = 1'b0; branchOffset = '0;
        fill(INC);
        @(negedge clk);
        tick();
        reset = 1'b0;
        chk("rst_addr", instrAddr, 0);
        chk("rst_run", running, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cycleCount, 0);
        chk("rst_op", opcode, 3'b110);
        chk("rst_opnd", operand, 0);

        // sequential fetch
        do_start();
        chk("t1_addr0", instrAddr, 0);
        chk("t1_run", running, 1);
        chk("t1_op", opcode, 3'b001);
        chk("t1_lb", lastBit, 1);
        chk("t1_opnd", operand, 1);
        tick(); chk("t1_addr1", instrAddr, 1);
        tick(); chk("t1_addr2", instrAddr, 2);
        start = 1'b1;
        tick(); chk("t1_addr3_start_ignored", instrAddr, 3);
        start = 1'b0;

        // taken and not-taken branch at PC=5
        tick(); tick(); chk("t2_addr5", instrAddr, 5);
        controlBranch = 1'b1; aluZero = 1'b1; branchOffset = 8'hFD;
        tick(); chk("t2_taken", instrAddr, 2);
        controlBranch = 1'b0; aluZero = 1'b0;
        tick(); tick(); tick(); chk("t2_addr5b", instrAddr, 5);
        controlBranch = 1'b1; aluZero = 1'b0;
        tick(); chk("t2_not_taken", instrAddr, 6);
        controlBranch = 1'b0;
        chk("t2_cnt", cycleCount, 10);

        // reset mid-RUN dominates start
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("t6_addr", instrAddr, 0);
        chk("t6_run", running, 0);
        chk("t6_done", done, 0);
        chk("t6_cnt", cycleCount, 0);
        chk("t6_op", opcode, 3'b110);
        tick(); chk("t6_idle_hold", instrAddr, 0);

        // halt at address 4
        fill(INC); mem[4] = 9'b111_000101;
        do_reset();
        do_start();
        tick(); tick(); tick(); tick();
        chk("t3_addr4", instrAddr, 4);
        chk("t3_op_run", opcode, 3'b111);
        chk("t3_opnd_run", operand, 5);
        tick();
        chk("t3_done", done, 1);
        chk("t3_run", running, 0);
        chk("t3_addr", instrAddr, 4);
        chk("t3_cnt", cycleCount, 5);
        chk("t3_op", opcode, 3'b110);
        chk("t3_opnd", operand, 0);
        chk("t3_lb", lastBit, 0);
        controlBranch = 1'b1; aluZero = 1'b1; branchOffset = 8'hFD;
        tick();
        chk("t3_hold_addr", instrAddr, 4);
        chk("t3_hold_cnt", cycleCount, 5);
        controlBranch = 1'b0; aluZero = 1'b0;
        do_start();
        chk("t6_restart_addr", instrAddr, 0);
        chk("t6_restart_run", running, 1);
        chk("t6_restart_done", done, 0);
        chk("t6_restart_cnt", cycleCount, 0);
        tick(); chk("t6_restart_addr1", instrAddr, 1);

        // 111 inside prep mode is not a halt
        fill(INC); mem[0] = PREP; mem[1] = 9'b111_000000;
        do_reset();
        do_start();
        chk("t4_prep0", dut.prep_shadow, 0);
        tick();
        chk("t4_addr1", instrAddr, 1);
        chk("t4_prep1", dut.prep_shadow, 1);
        tick();
        chk("t4_addr2", instrAddr, 2);
        chk("t4_run", running, 1);
        chk("t4_done", done, 0);
        chk("t4_prep2", dut.prep_shadow, 1);
        tick();
        chk("t4_prep3", dut.prep_shadow, 0);

        // PC wrap both directions, then counter saturation
        fill(INC);
        do_reset();
        do_start();
        tick(); chk("t5_addr1", instrAddr, 1);
        controlBranch = 1'b1; aluZero = 1'b1; branchOffset = 8'hFE;
        tick(); chk("t5_neg_wrap", instrAddr, 1023);
        controlBranch = 1'b0; aluZero = 1'b0;
        tick(); chk("t5_pos_wrap", instrAddr, 0);
        chk("t5_cnt3", cycleCount, 3);
        for (int i = 0; i < 65532; i++) tick();
        chk("sat_max", cycleCount, 16'hFFFF);
        tick();
        chk("sat_hold", cycleCount, 16'hFFFF);
        chk("sat_run", running, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
